// File: rtl/arith_pkg.sv
// Shared arithmetic definitions: serial FSM state encoding and default widths.
package arith_pkg;

    localparam int SERIAL_WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } serial_state_t;

    // Bit-counter width; a 1-bit operand still needs a 1-bit counter.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: diff = a - b - b_in, borrow set when the result underflows.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic b_in,
    output logic diff,
    output logic borrow
);

    assign diff   = a ^ b ^ b_in;
    assign borrow = (~a & b) | (~(a ^ b) & b_in);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor, LSB first, one bit per clock, with valid/ready on both sides.
// Handshake: a transfer happens on a rising edge where valid & ready are both high;
// the producer holds data stable while valid is high and ready is low.
module serial_subtractor
    import arith_pkg::*;
#(
    parameter int WIDTH = SERIAL_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] minuend,
    input  logic [WIDTH-1:0] subtrahend,
    input  logic             b_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             b_out,
    output logic [1:0]       dbg_state
);

    localparam int            CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    serial_state_t    state, state_nx;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_sr, b_sr, r_sr, r_shift;
    logic             borrow, cell_d, cell_b, accept, last_bit;

    full_subtractor u_cell (
        .a      (a_sr[0]),
        .b      (b_sr[0]),
        .b_in   (borrow),
        .diff   (cell_d),
        .borrow (cell_b)
    );

    assign accept   = in_valid & in_ready;
    assign last_bit = (cnt == LAST);

    // New diff bit enters at the MSB so the result lands LSB-aligned after WIDTH shifts.
    if (WIDTH == 1) begin : g_w1
        assign r_shift = cell_d;
    end else begin : g_wn
        assign r_shift = {cell_d, r_sr[WIDTH-1:1]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                // Gated by reset so nothing is offered while the block is held in reset.
                in_ready = rst_n;
                if (in_valid && rst_n) begin
                    state_nx = RUN;
                end
            end
            RUN: begin
                if (last_bit) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            a_sr   <= '0;
            b_sr   <= '0;
            r_sr   <= '0;
            borrow <= 1'b0;
        end else if (accept) begin
            cnt    <= '0;
            a_sr   <= minuend;
            b_sr   <= subtrahend;
            r_sr   <= '0;
            borrow <= b_in;
        end else if (state == RUN) begin
            cnt    <= cnt + 1'b1;
            a_sr   <= a_sr >> 1;
            b_sr   <= b_sr >> 1;
            r_sr   <= r_shift;
            borrow <= cell_b;
        end
    end

    // Outputs come straight from registers; they only change on load or while running.
    assign diff      = r_sr;
    assign b_out     = borrow;
    assign dbg_state = state;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (WIDTH 8 and 4 instances) and the full_subtractor cell.
module tb_serial_subtractor;
    import arith_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // ---------------- WIDTH 8 instance ----------------
    logic       in_valid_8 = 1'b0, in_ready_8, b_in_8 = 1'b0;
    logic [7:0] minuend_8 = '0, subtrahend_8 = '0, diff_8;
    logic       out_valid_8, out_ready_8 = 1'b0, b_out_8;
    logic [1:0] dbg_state_8;

    serial_subtractor #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid_8), .in_ready(in_ready_8),
        .minuend(minuend_8), .subtrahend(subtrahend_8), .b_in(b_in_8),
        .out_valid(out_valid_8), .out_ready(out_ready_8),
        .diff(diff_8), .b_out(b_out_8), .dbg_state(dbg_state_8)
    );

    // ---------------- WIDTH 4 instance ----------------
    logic       in_valid_4 = 1'b0, in_ready_4, b_in_4 = 1'b0;
    logic [3:0] minuend_4 = '0, subtrahend_4 = '0, diff_4;
    logic       out_valid_4, out_ready_4 = 1'b0, b_out_4;
    logic [1:0] dbg_state_4;

    serial_subtractor #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid_4), .in_ready(in_ready_4),
        .minuend(minuend_4), .subtrahend(subtrahend_4), .b_in(b_in_4),
        .out_valid(out_valid_4), .out_ready(out_ready_4),
        .diff(diff_4), .b_out(b_out_4), .dbg_state(dbg_state_4)
    );

    // ---------------- full subtractor cell ----------------
    logic fs_a = 1'b0, fs_b = 1'b0, fs_bin = 1'b0, fs_d, fs_bout;

    full_subtractor u_fs (
        .a(fs_a), .b(fs_b), .b_in(fs_bin), .diff(fs_d), .borrow(fs_bout)
    );

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Offer one operand set to the 8-bit instance, check latency and result; leaves it in DONE.
    task automatic run8(input string tag, input logic [7:0] m, input logic [7:0] s,
                        input logic bi, input logic [7:0] exp_d, input logic exp_b);
        int edges;
        @(negedge clk);
        check({tag, "_in_ready"}, 32'(in_ready_8), 32'd1);
        in_valid_8 = 1'b1; minuend_8 = m; subtrahend_8 = s; b_in_8 = bi;
        @(posedge clk);
        #1;
        // Scramble inputs after the accept edge; they must have no effect.
        in_valid_8 = 1'b0;
        minuend_8 = 8'($urandom); subtrahend_8 = 8'($urandom); b_in_8 = 1'($urandom);
        edges = 0;
        while (edges < 40) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (out_valid_8) break;
        end
        check({tag, "_latency"}, 32'(edges), 32'd8);
        check({tag, "_diff"}, 32'(diff_8), 32'(exp_d));
        check({tag, "_bout"}, 32'(b_out_8), 32'(exp_b));
    endtask

    task automatic release8();
        @(negedge clk);
        out_ready_8 = 1'b1;
        @(posedge clk);
        #1 out_ready_8 = 1'b0;
    endtask

    // ---------------- scoreboard for the exhaustive sweep ----------------
    logic [4:0] exp_q[$];

    task automatic run4(input logic [3:0] m, input logic [3:0] s, input logic bi);
        int run_cnt;
        bit done;
        logic [4:0] exp;
        in_valid_4 = 1'b1; minuend_4 = m; subtrahend_4 = s; b_in_4 = bi;
        @(posedge clk);
        // 5-bit wrap of the difference: bit 4 is the borrow-out.
        exp_q.push_back(5'({1'b0, m} - {1'b0, s} - {4'd0, bi}));
        #1 in_valid_4 = 1'b0;
        run_cnt = 0;
        done = 1'b0;
        for (int t = 0; t < 64 && !done; t++) begin
            @(negedge clk);
            if (dbg_state_4 == 2'(RUN)) run_cnt++;
            if (out_valid_4) begin
                out_ready_4 = ($urandom_range(0, 3) != 0);
                if (out_ready_4) begin
                    exp = exp_q.pop_front();
                    check("exh_result", 32'({b_out_4, diff_4}), 32'(exp));
                    done = 1'b1;
                end
            end
        end
        if (!done) check("exh_timeout", 32'(done), 32'd1);
        check("exh_run_cycles", 32'(run_cnt), 32'd4);
        @(posedge clk);
        #1 out_ready_4 = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    logic [1:0] fs_tbl [8] = '{2'b00, 2'b11, 2'b11, 2'b01, 2'b10, 2'b00, 2'b00, 2'b11};
    logic [7:0] held_d;
    logic       held_b;

    initial begin
        // Reset state while held low.
        #3;
        check("rst_out_valid", 32'(out_valid_8), 32'd0);
        check("rst_diff", 32'(diff_8), 32'd0);
        check("rst_bout", 32'(b_out_8), 32'd0);
        check("rst_in_ready", 32'(in_ready_8), 32'd0);
        check("rst_state", 32'(dbg_state_8), 32'(IDLE));
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        #1 check("rst_release_in_ready", 32'(in_ready_8), 32'd1);

        // Cell truth table, {d, bout} per {a, b, bin}.
        for (int i = 0; i < 8; i++) begin
            {fs_a, fs_b, fs_bin} = 3'(i);
            #1 check($sformatf("fs_%0d", i), 32'({fs_d, fs_bout}), 32'(fs_tbl[i]));
        end

        // Basic and underflow cases.
        run8("basic", 8'd100, 8'd37, 1'b0, 8'd63, 1'b0);   release8();
        run8("under", 8'd5, 8'd9, 1'b0, 8'd252, 1'b1);     release8();
        run8("zero_bin", 8'd0, 8'd0, 1'b1, 8'd255, 1'b1);  release8();
        run8("exact", 8'd200, 8'd199, 1'b1, 8'd0, 1'b0);   release8();

        // Backpressure: result holds and no new operands are taken.
        run8("bp", 8'd17, 8'd200, 1'b0, 8'd73, 1'b1);
        held_d = diff_8;
        held_b = b_out_8;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            in_valid_8 = ~in_valid_8;
            minuend_8 = 8'($urandom); subtrahend_8 = 8'($urandom); b_in_8 = 1'($urandom);
            #1;
            check("bp_diff", 32'(diff_8), 32'(held_d));
            check("bp_bout", 32'(b_out_8), 32'(held_b));
            check("bp_in_ready", 32'(in_ready_8), 32'd0);
            check("bp_out_valid", 32'(out_valid_8), 32'd1);
        end
        @(negedge clk);
        in_valid_8 = 1'b0;
        out_ready_8 = 1'b1;
        @(posedge clk);
        #1 out_ready_8 = 1'b0;
        @(negedge clk);
        check("bp_release_state", 32'(dbg_state_8), 32'(IDLE));
        check("bp_release_in_ready", 32'(in_ready_8), 32'd1);
        check("bp_hold_after_diff", 32'(diff_8), 32'(held_d));

        // Reset in the middle of RUN (bits 0..2 done, bit 3 in progress).
        @(negedge clk);
        in_valid_8 = 1'b1; minuend_8 = 8'd77; subtrahend_8 = 8'd11; b_in_8 = 1'b0;
        @(posedge clk);
        #1 in_valid_8 = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 32'(out_valid_8), 32'd0);
        check("mid_rst_diff", 32'(diff_8), 32'd0);
        check("mid_rst_bout", 32'(b_out_8), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready_8), 32'd0);
        check("mid_rst_state", 32'(dbg_state_8), 32'(IDLE));
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("mid_rst_release_in_ready", 32'(in_ready_8), 32'd1);
        begin
            int seen = 0;
            for (int c = 0; c < 12; c++) begin
                @(negedge clk);
                if (out_valid_8) seen++;
            end
            check("mid_rst_no_out_valid", 32'(seen), 32'd0);
        end
        run8("after_rst", 8'd50, 8'd20, 1'b0, 8'd30, 1'b0); release8();

        // Exhaustive sweep of the 4-bit instance with random output stalls.
        @(posedge clk);
        #1;
        for (int i = 0; i < 512; i++) begin
            logic [8:0] v;
            v = 9'(i);
            run4(v[7:4], v[3:0], v[8]);
        end
        check("exh_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
